// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a registered result stage and a multi-cycle
// radix-2 shift-add multiplier.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready is combinational on state and out_ready
//   InA, InB            operands (W bits); InB[SHAMT_WIDTH-1:0] is the shift amount
//   Cin                 carry-in for add
//   Oper                operation select (rotate, shifts, add, logic, multiply)
//   invA, invB          invert the operand before use
//   sign                signed interpretation for Ofl and multiply
//   out_valid/out_ready result handshake
//   Out, Out_hi         result; {Out_hi, Out} is the full product for multiply
//   Zero, Ofl           Out == 0, and the overflow flag
module alu_seq #(
  parameter int unsigned OPERAND_WIDTH = 16,
  parameter int unsigned SHAMT_WIDTH   = $clog2(OPERAND_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] InA,
  input  logic [OPERAND_WIDTH-1:0] InB,
  input  logic                     Cin,
  input  logic [3:0]               Oper,
  input  logic                     invA,
  input  logic                     invB,
  input  logic                     sign,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] Out,
  output logic [OPERAND_WIDTH-1:0] Out_hi,
  output logic                     Zero,
  output logic                     Ofl
);

  localparam int unsigned W    = OPERAND_WIDTH;
  localparam int unsigned CntW = $clog2(OPERAND_WIDTH + 1);
  localparam logic [CntW-1:0] MulIters = CntW'(OPERAND_WIDTH);

  localparam logic [3:0] OpRol = 4'b0000;
  localparam logic [3:0] OpShl = 4'b0001;
  localparam logic [3:0] OpSra = 4'b0010;
  localparam logic [3:0] OpSrl = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpOr  = 4'b0110;
  localparam logic [3:0] OpXor = 4'b0111;
  localparam logic [3:0] OpMul = 4'b1000;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e state_q, state_d;

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_q, out_d;
  logic [W-1:0]    out_hi_q, out_hi_d;
  logic            zero_q, zero_d;
  logic            ofl_q, ofl_d;

  // Multiplier working state: multiplicand magnitude, {acc, multiplier} product
  // register, result-negate flag, signedness for Ofl, iteration count.
  logic [W-1:0]    mcand_q, mcand_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic            neg_q, neg_d;
  logic            msign_q, msign_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Conditioned operands and single-cycle datapath
  logic [W-1:0]           a_c, b_c;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [2*W-1:0]         rot_full;
  logic [W:0]             add_full;
  logic [W-1:0]           alu_res;
  logic                   alu_ofl;
  logic                   a_neg, b_neg;
  logic [W-1:0]           mag_a, mag_b;

  always_comb begin
    a_c      = invA ? ~InA : InA;
    b_c      = invB ? ~InB : InB;
    shamt    = b_c[SHAMT_WIDTH-1:0];
    // Upper half of {A', A'} shifted left is A' rotated left.
    rot_full = {a_c, a_c} << shamt;
    add_full = {1'b0, a_c} + {1'b0, b_c} + {{W{1'b0}}, Cin};

    // Add is the default so reserved opcodes fall through to it.
    alu_res = add_full[W-1:0];
    alu_ofl = sign ? ((a_c[W-1] == b_c[W-1]) && (add_full[W-1] != a_c[W-1]))
                   : add_full[W];
    case (Oper)
      OpRol: begin alu_res = rot_full[2*W-1:W];        alu_ofl = 1'b0; end
      OpShl: begin alu_res = a_c << shamt;             alu_ofl = 1'b0; end
      OpSra: begin alu_res = $signed(a_c) >>> shamt;   alu_ofl = 1'b0; end
      OpSrl: begin alu_res = a_c >> shamt;             alu_ofl = 1'b0; end
      OpAnd: begin alu_res = a_c & b_c;                alu_ofl = 1'b0; end
      OpOr:  begin alu_res = a_c | b_c;                alu_ofl = 1'b0; end
      OpXor: begin alu_res = a_c ^ b_c;                alu_ofl = 1'b0; end
      default: ;
    endcase

    a_neg = sign & a_c[W-1];
    b_neg = sign & b_c[W-1];
    mag_a = a_neg ? -a_c : a_c;
    mag_b = b_neg ? -b_c : b_c;
  end

  // Multiplier iteration and final sign fix-up
  logic [W:0]     partial;
  logic [2*W-1:0] step_prod;
  logic [2*W-1:0] fin_prod;
  logic [W-1:0]   fin_lo, fin_hi;
  logic           fin_ofl;

  always_comb begin
    partial   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    step_prod = {partial, prod_q[W-1:1]};
    fin_prod  = neg_q ? -prod_q : prod_q;
    fin_lo    = fin_prod[W-1:0];
    fin_hi    = fin_prod[2*W-1:W];
    fin_ofl   = msign_q ? (fin_hi != {W{fin_lo[W-1]}}) : (fin_hi != {W{1'b0}});
  end

  logic accept;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_hi_d    = out_hi_q;
    zero_d      = zero_q;
    ofl_d       = ofl_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    neg_d       = neg_q;
    msign_d     = msign_q;
    cnt_d       = cnt_q;

    in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      StIdle: ;
      StMul: begin
        if (cnt_q == MulIters) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_d       = fin_lo;
          out_hi_d    = fin_hi;
          zero_d      = (fin_lo == {W{1'b0}});
          ofl_d       = fin_ofl;
        end else begin
          prod_d = step_prod;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new request overrides the retire path above, giving same-cycle accept in DONE.
    if (accept) begin
      if (Oper == OpMul) begin
        state_d     = StMul;
        out_valid_d = 1'b0;
        mcand_d     = mag_a;
        prod_d      = {{W{1'b0}}, mag_b};
        neg_d       = a_neg ^ b_neg;
        msign_d     = sign;
        cnt_d       = '0;
      end else begin
        state_d     = StDone;
        out_valid_d = 1'b1;
        out_d       = alu_res;
        out_hi_d    = {W{1'b0}};
        zero_d      = (alu_res == {W{1'b0}});
        ofl_d       = alu_ofl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_hi_q    <= '0;
      zero_q      <= 1'b0;
      ofl_q       <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      neg_q       <= 1'b0;
      msign_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_hi_q    <= out_hi_d;
      zero_q      <= zero_d;
      ofl_q       <= ofl_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      neg_q       <= neg_d;
      msign_q     <= msign_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Out       = out_q;
  assign Out_hi    = out_hi_q;
  assign Zero      = zero_q;
  assign Ofl       = ofl_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (W = 16). Directed cases plus
// randomized traffic checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ina, inb;
  logic         cin;
  logic [3:0]   oper;
  logic         inv_a, inv_b, sgn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_lo, out_hi;
  logic         zero, ofl;

  int checks = 0;
  int errors = 0;

  alu_seq #(.OPERAND_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .InA      (ina),
    .InB      (inb),
    .Cin      (cin),
    .Oper     (oper),
    .invA     (inv_a),
    .invB     (inv_b),
    .sign     (sgn),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out      (out_lo),
    .Out_hi   (out_hi),
    .Zero     (zero),
    .Ofl      (ofl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the conditioned operands.
  function automatic void model(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                input logic c_in, input logic [3:0] op,
                                input logic ia, input logic ib, input logic sg,
                                output logic [W-1:0] e_lo, output logic [W-1:0] e_hi,
                                output logic e_ofl, output logic e_zero);
    logic [W-1:0] a, b;
    longint ua, ub, sa, sb, p, lim, full;
    int sh;
    a    = ia ? ~a_in : a_in;
    b    = ib ? ~b_in : b_in;
    ua   = longint'(a);
    ub   = longint'(b);
    full = longint'(1) << W;
    lim  = longint'(1) << (W - 1);
    sa   = a[W-1] ? ua - full : ua;
    sb   = b[W-1] ? ub - full : ub;
    sh   = int'(ub % longint'(W));
    e_hi  = '0;
    e_ofl = 1'b0;
    case (op)
      4'd0: begin
        e_lo = a;
        for (int i = 0; i < sh; i++) e_lo = {e_lo[W-2:0], e_lo[W-1]};
      end
      4'd1: begin p = ua << sh;  e_lo = p[W-1:0]; end
      4'd2: begin p = sa >>> sh; e_lo = p[W-1:0]; end
      4'd3: begin p = ua >> sh;  e_lo = p[W-1:0]; end
      4'd5: e_lo = a & b;
      4'd6: e_lo = a | b;
      4'd7: e_lo = a ^ b;
      4'd8: begin
        p     = sg ? sa * sb : ua * ub;
        e_lo  = p[W-1:0];
        e_hi  = p[2*W-1:W];
        e_ofl = sg ? (p < -lim || p > lim - 1) : (p >= full);
      end
      default: begin
        if (sg) begin
          p     = sa + sb + longint'(c_in);
          e_ofl = (p < -lim || p > lim - 1);
        end else begin
          p     = ua + ub + longint'(c_in);
          e_ofl = (p >= full);
        end
        e_lo = p[W-1:0];
      end
    endcase
    e_zero = (e_lo == '0);
  endfunction

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom());
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [3:0] op, input logic ia, input logic ib, input logic sg);
    ina = a; inb = b; cin = c; oper = op; inv_a = ia; inv_b = ib; sgn = sg;
    in_valid = 1'b1;
  endtask

  // Wait (bounded) for out_valid; reports cycles waited and whether in_ready rose.
  task automatic wait_out(output int cyc, output logic rdy_seen);
    cyc = 0;
    rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive('0, '0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_lo, out_hi, zero, ofl} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b out=%h hi=%h z=%b o=%b, expected all 0",
               out_valid, out_lo, out_hi, zero, ofl);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    drive(16'h7FFF, 16'h0001, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_lo, ofl, zero} !== {1'b1, 16'h8000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_signed: got v=%b out=%h o=%b z=%b expected v=1 out=8000 o=1 z=0",
               out_valid, out_lo, ofl, zero);
    end
    drive(16'h7FFF, 16'h0001, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_lo, ofl, zero} !== {1'b1, 16'h8000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_unsigned: got v=%b out=%h o=%b z=%b expected v=1 out=8000 o=0 z=0",
               out_valid, out_lo, ofl, zero);
    end
  endtask

  task automatic test_sub();
    drive(16'h1234, 16'h1234, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_lo, out_hi, zero, ofl} !== {1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_equal: got v=%b out=%h hi=%h z=%b o=%b expected v=1 out=0 hi=0 z=1 o=1",
               out_valid, out_lo, out_hi, zero, ofl);
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] exp1 [4];
    logic [W-1:0] amts [3];
    logic [W-1:0] expv;
    exp1 = '{16'h0003, 16'h0002, 16'hC000, 16'h4000};
    amts = '{16'h0001, 16'h0000, 16'hFFF1};  // FFF1: upper bits ignored, amount 1
    for (int k = 0; k < 3; k++) begin
      for (int op = 0; op < 4; op++) begin
        drive(16'h8001, amts[k], 1'b0, 4'(op), 1'b0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        expv = (k == 1) ? 16'h8001 : exp1[op];
        checks++;
        if ({out_valid, out_lo, out_hi, ofl} !== {1'b1, expv, 16'h0000, 1'b0}) begin
          errors++;
          $display("FAIL shift op%0d amt=%h: got out=%h hi=%h o=%b expected out=%h hi=0 o=0",
                   op, amts[k], out_lo, out_hi, ofl, expv);
        end
      end
    end
    // Rotate left by W-1 is rotate right by 1.
    drive(16'h8001, 16'h000F, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_lo !== 16'hC000) begin
      errors++;
      $display("FAIL rotate_w_minus_1: got %h expected c000", out_lo);
    end
  endtask

  task automatic test_mul();
    int cyc;
    logic rdy;
    drive(16'hFFFE, 16'h0003, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    wait_out(cyc, rdy);
    checks++;
    if (cyc != W + 1 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL mul_signed_latency: got %0d cycles ready_seen=%b expected %0d and 0",
               cyc, rdy, W + 1);
    end
    checks++;
    if ({out_hi, out_lo, ofl, zero} !== {32'hFFFF_FFFA, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_signed: got %h_%h o=%b z=%b expected ffff_fffa o=0 z=0",
               out_hi, out_lo, ofl, zero);
    end
    drive(16'hFFFF, 16'h0002, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    wait_out(cyc, rdy);
    checks++;
    if (cyc != W + 1 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL mul_unsigned_latency: got %0d cycles ready_seen=%b expected %0d and 0",
               cyc, rdy, W + 1);
    end
    checks++;
    if ({out_hi, out_lo, ofl} !== {16'h0001, 16'hFFFE, 1'b1}) begin
      errors++;
      $display("FAIL mul_unsigned: got %h_%h o=%b expected 0001_fffe o=1", out_hi, out_lo, ofl);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e1, e2, eh;
    logic eo, ez;
    model(16'h0100, 16'h0023, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, e1, eh, eo, ez);
    model(16'h00FF, 16'h0F0F, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, e2, eh, eo, ez);
    drive(16'h0100, 16'h0023, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    drive(16'h00FF, 16'h0F0F, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready_low: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({out_valid, in_ready, out_lo} !== {1'b1, 1'b0, e1}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b rdy=%b out=%h expected v=1 rdy=0 out=%h",
                 i, out_valid, in_ready, out_lo, e1);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_lo} !== {1'b1, e2}) begin
      errors++;
      $display("FAIL bp_new_accept: got v=%b out=%h expected v=1 out=%h", out_valid, out_lo, e2);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] el, eh;
    logic eo, ez;
    drive(16'h1234, 16'h5678, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_lo, out_hi, in_ready} !== {1'b0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_mul: got v=%b out=%h hi=%h rdy=%b expected v=0 out=0 hi=0 rdy=1",
               out_valid, out_lo, out_hi, in_ready);
    end
    repeat (W + 2) step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul_stale: got out_valid=%b expected 0", out_valid);
    end
    model(16'h0005, 16'h0007, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, el, eh, eo, ez);
    drive(16'h0005, 16'h0007, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_lo, ofl, zero} !== {1'b1, el, eo, ez}) begin
      errors++;
      $display("FAIL add_after_reset: got v=%b out=%h o=%b z=%b expected v=1 out=%h o=%b z=%b",
               out_valid, out_lo, ofl, zero, el, eo, ez);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, el, eh;
    logic c, ia, ib, sg, eo, ez;
    logic [3:0] op;
    for (int i = 0; i < 20; i++) begin
      a = rnd_val(); b = rnd_val();
      c = 1'($urandom()); ia = 1'($urandom()); ib = 1'($urandom()); sg = 1'($urandom());
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd8) op = op + 4'd1;
      model(a, b, c, op, ia, ib, sg, el, eh, eo, ez);
      drive(a, b, c, op, ia, ib, sg);
      step();
      checks++;
      if ({out_valid, out_hi, out_lo, ofl, zero} !== {1'b1, eh, el, eo, ez}) begin
        errors++;
        $display("FAIL b2b %0d op=%h: got v=%b %h_%h o=%b z=%b expected v=1 %h_%h o=%b z=%b",
                 i, op, out_valid, out_hi, out_lo, ofl, zero, eh, el, eo, ez);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, el, eh;
    logic c, ia, ib, sg, eo, ez, rdy;
    logic [3:0] op;
    int cyc, hold, exp_cyc;
    for (int i = 0; i < 40; i++) begin
      a = rnd_val(); b = rnd_val();
      c = 1'($urandom()); ia = 1'($urandom()); ib = 1'($urandom()); sg = 1'($urandom());
      op = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      model(a, b, c, op, ia, ib, sg, el, eh, eo, ez);
      drive(a, b, c, op, ia, ib, sg);
      step();
      in_valid = 1'b0;
      wait_out(cyc, rdy);
      exp_cyc = (op == 4'd8) ? W + 1 : 0;
      checks++;
      if (cyc != exp_cyc || rdy !== 1'b0) begin
        errors++;
        $display("FAIL rnd_latency %0d op=%h: got %0d cycles ready_seen=%b expected %0d and 0",
                 i, op, cyc, rdy, exp_cyc);
      end
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      for (int h = 0; h <= hold; h++) begin
        checks++;
        if ({out_valid, out_hi, out_lo, ofl, zero} !== {1'b1, eh, el, eo, ez}) begin
          errors++;
          $display("FAIL rnd %0d op=%h a=%h b=%h: got v=%b %h_%h o=%b z=%b expected %h_%h o=%b z=%b",
                   i, op, a, b, out_valid, out_hi, out_lo, ofl, zero, eh, el, eo, ez);
        end
        if (h < hold) step();
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
